// File: rtl/fetch_queue.sv
// Instruction fetch front end: a PC register issues one memory request at a time and
// queues the returned words with their PC in a DEPTH-entry FIFO for decode.
module fetch_queue #(
  parameter int             N        = 64,
  parameter int             DEPTH    = 4,
  parameter int             INC      = 4,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         PCSrc_F,
  input  logic [N-1:0]                 PCBranch_F,
  output logic                         imem_req,
  output logic [N-1:0]                 imem_addr_F,
  input  logic                         imem_ready,
  input  logic                         imem_rvalid,
  input  logic [31:0]                  imem_rdata,
  output logic                         out_valid,
  output logic [31:0]                  out_instr,
  output logic [N-1:0]                 out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    pc;
  logic [N-1:0]    req_pc;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [31:0]     q_instr [DEPTH];
  logic [N-1:0]    q_pc    [DEPTH];

  logic accept, push, pop;

  // A request is only issued when a queue slot is guaranteed for its response.
  assign imem_req    = (state == IDLE) && (count < CW'(DEPTH)) && !reset;
  assign imem_addr_F = pc;
  assign accept      = imem_req && imem_ready;
  assign push        = (state == WAIT) && imem_rvalid && !PCSrc_F;
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;
  assign out_instr   = out_valid ? q_instr[rd_ptr] : 32'h0;
  assign out_pc      = out_valid ? q_pc[rd_ptr]    : '0;

  always_comb begin
    state_nxt = state;
    if (PCSrc_F) begin
      // Anything still in flight after the redirect cycle belongs to the old path.
      if (((state == WAIT) && !imem_rvalid) ||
          ((state == DROP) && !imem_rvalid) ||
          ((state == IDLE) && accept))
        state_nxt = DROP;
      else
        state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept)      state_nxt = WAIT;
        WAIT:    if (imem_rvalid) state_nxt = IDLE;
        DROP:    if (imem_rvalid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (PCSrc_F) begin
        pc <= PCBranch_F;
      end else if (accept) begin
        pc     <= pc + N'(INC);
        req_pc <= pc;
      end

      if (PCSrc_F) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr]    <= req_pc;
          wr_ptr          <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model with programmable latency, PC model and a
// scoreboard of expected queue entries; a second 32-bit instance checks PC wrap.
module tb_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, PCSrc_F, imem_req, imem_ready, imem_rvalid, out_valid, out_ready;
  logic [63:0] PCBranch_F, imem_addr_F, out_pc;
  logic [31:0] imem_rdata, out_instr;
  logic [2:0]  count;

  fetch_queue u_dut (
    .clk(clk), .reset(reset), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
    .imem_req(imem_req), .imem_addr_F(imem_addr_F), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready), .count(count)
  );

  logic        r2, req2, rdy2, rv2, ov2;
  logic [31:0] addr2, oi2, op2;
  logic [2:0]  cnt2;

  fetch_queue #(.N(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(r2), .PCSrc_F(1'b0), .PCBranch_F(32'h0),
    .imem_req(req2), .imem_addr_F(addr2), .imem_ready(rdy2),
    .imem_rvalid(rv2), .imem_rdata(32'h1234_5678), .out_valid(ov2),
    .out_instr(oi2), .out_pc(op2), .out_ready(1'b0), .count(cnt2)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  ent_t        sb[$];
  logic [63:0] issued[$];
  int          n_chk = 0;
  int          n_pass = 0;

  logic [63:0] exp_pc;
  logic        pend_v;
  logic [63:0] pend_addr;
  logic        m_busy;
  int          m_cnt;
  logic [63:0] m_addr;
  int          lat;

  function automatic logic [31:0] word_of(logic [63:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a falling edge with inputs set; observes, updates the models, advances one cycle.
  task automatic cycle();
    logic acc, rsp, nrv;
    logic [31:0] ndat;
    ent_t e;
    #1;
    acc = imem_req && imem_ready;
    rsp = imem_rvalid;
    if (reset) begin
      check("req_in_reset", {63'd0, imem_req}, 64'd0);
      sb.delete();
      pend_v = 1'b0;
      exp_pc = 64'd0;
    end else begin
      check("count", {61'd0, count}, 64'(sb.size()));
      check("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
      if (imem_req) check("req_addr", imem_addr_F, exp_pc);
      if (!out_valid) begin
        check("idle_instr", {32'd0, out_instr}, 64'd0);
        check("idle_pc", out_pc, 64'd0);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("head_pc", out_pc, e.pc);
        check("head_instr", {32'd0, out_instr}, {32'd0, e.instr});
      end
      if (acc) issued.push_back(imem_addr_F);
      if (PCSrc_F) begin
        sb.delete();
        pend_v = 1'b0;
        exp_pc = PCBranch_F;
      end else begin
        if (rsp && pend_v) begin
          e.instr = word_of(pend_addr);
          e.pc    = pend_addr;
          sb.push_back(e);
          pend_v = 1'b0;
        end
        if (acc) begin
          pend_v    = 1'b1;
          pend_addr = imem_addr_F;
          exp_pc    = exp_pc + 64'd4;
        end
      end
    end
    nrv  = 1'b0;
    ndat = 32'hDEAD_BEEF;
    if (acc) begin
      m_busy = 1'b1;
      m_cnt  = lat;
      m_addr = imem_addr_F;
    end
    if (m_busy) begin
      if (m_cnt == 0) begin
        nrv    = 1'b1;
        ndat   = word_of(m_addr);
        m_busy = 1'b0;
      end else begin
        m_cnt--;
      end
    end
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = nrv;
    imem_rdata  = ndat;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b1; PCSrc_F = 1'b0; PCBranch_F = '0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    r2 = 1'b1; rdy2 = 1'b0; rv2 = 1'b0;
    exp_pc = '0; pend_v = 1'b0; pend_addr = '0; m_busy = 1'b0; m_cnt = 0; m_addr = '0; lat = 0;

    // 32-bit instance: first request at the top of the address space, then wrap to 0.
    @(negedge clk);
    @(negedge clk);
    r2 = 1'b0; rdy2 = 1'b1;
    #1;
    check("wrap_first_req", {63'd0, req2}, 64'd1);
    check("wrap_first_addr", {32'd0, addr2}, 64'h0000_0000_FFFF_FFFC);
    @(negedge clk);
    rv2 = 1'b1;
    #1;
    check("wrap_wait_req", {63'd0, req2}, 64'd0);
    @(negedge clk);
    rv2 = 1'b0;
    #1;
    check("wrap_second_req", {63'd0, req2}, 64'd1);
    check("wrap_second_addr", {32'd0, addr2}, 64'd0);
    check("wrap_count", {61'd0, cnt2}, 64'd1);
    rdy2 = 1'b0;
    @(negedge clk);

    // Reset state.
    do_reset();
    #1;
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_addr", imem_addr_F, 64'd0);
    check("rst_req_ready0", {63'd0, imem_req}, 64'd1);

    // Fill with out_ready low.
    imem_ready = 1'b1; lat = 0; issued.delete();
    repeat (12) cycle();
    check("fill_count", {61'd0, count}, 64'd4);
    check("fill_issued", 64'(issued.size()), 64'd4);
    for (int i = 0; i < 4 && i < issued.size(); i++)
      check("fill_addr", issued[i], 64'(4 * i));
    repeat (3) begin
      check("full_no_req", {63'd0, imem_req}, 64'd0);
      cycle();
    end

    // One pop frees one slot; the next request goes to 16.
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    #1;
    check("pop_count", {61'd0, count}, 64'd3);
    check("pop_req", {63'd0, imem_req}, 64'd1);
    check("pop_addr", imem_addr_F, 64'd16);

    // Redirect while the request to 0x8 is outstanding.
    do_reset();
    k = 0;
    while (!(imem_req && imem_addr_F == 64'h8) && k < 50) begin cycle(); k++; end
    check("wait_req8", {63'd0, imem_req && imem_addr_F == 64'h8}, 64'd1);
    lat = 2;
    cycle();
    lat = 0;
    check("req8_pending", {63'd0, imem_rvalid}, 64'd0);
    PCSrc_F = 1'b1; PCBranch_F = 64'h100;
    cycle();
    PCSrc_F = 1'b0;
    #1;
    check("redir_count", {61'd0, count}, 64'd0);
    check("redir_valid", {63'd0, out_valid}, 64'd0);
    check("drop_no_req", {63'd0, imem_req}, 64'd0);
    issued.delete();
    k = 0;
    while (issued.size() == 0 && k < 50) begin cycle(); k++; end
    check("redir_issued", 64'(issued.size()), 64'd1);
    if (issued.size() != 0) check("redir_target", issued[0], 64'h100);

    // Redirect coinciding with a response.
    k = 0;
    while (!imem_rvalid && k < 50) begin cycle(); k++; end
    check("wait_rvalid", {63'd0, imem_rvalid}, 64'd1);
    PCSrc_F = 1'b1; PCBranch_F = 64'h200;
    cycle();
    PCSrc_F = 1'b0;
    #1;
    check("same_req", {63'd0, imem_req}, 64'd1);
    check("same_addr", imem_addr_F, 64'h200);
    check("same_count", {61'd0, count}, 64'd0);

    // Push and pop together at count 2.
    k = 0;
    while (!(count == 3'd2 && imem_rvalid) && k < 50) begin cycle(); k++; end
    check("wait_cnt2", {63'd0, count == 3'd2 && imem_rvalid}, 64'd1);
    out_ready = 1'b1;
    cycle();
    #1;
    check("pushpop_count", {61'd0, count}, 64'd2);
    repeat (10) cycle();
    out_ready = 1'b0;

    // Reset with a request in flight; the late response must be ignored.
    lat = 1;
    k = 0;
    while (!imem_req && k < 50) begin cycle(); k++; end
    cycle();
    lat = 0;
    do_reset();
    imem_ready = 1'b0;
    repeat (4) cycle();
    check("late_rsp_count", {61'd0, count}, 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      imem_ready = ($urandom_range(3) != 0);
      out_ready  = ($urandom_range(1) != 0);
      PCSrc_F    = ($urandom_range(19) == 0);
      PCBranch_F = {$urandom, $urandom} & ~64'd3;
      lat        = $urandom_range(2);
      cycle();
    end
    PCSrc_F = 1'b0; imem_ready = 1'b0; out_ready = 1'b1;
    repeat (12) cycle();
    check("drain_count", {61'd0, count}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter N, default 64: PC and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: instruction queue entries; power of two, >= 2.
REQ-003 SHALL have parameter INC, default 4: sequential PC increment in bytes.
REQ-004 SHALL have parameter RESET_PC, default 0: PC value loaded by reset.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port PCSrc_F  in  1  redirect request (taken branch / flush).
REQ-008 SHALL have port PCBranch_F  in  N  redirect target PC.
REQ-009 SHALL have port imem_req  out  1  instruction memory request valid.
REQ-010 SHALL have port imem_addr_F  out  N  request address; equals the current PC.
REQ-011 SHALL have port imem_ready  in  1  memory accepts the request this cycle.
REQ-012 SHALL have port imem_rvalid  in  1  memory response valid.
REQ-013 SHALL have port imem_rdata  in  32  response instruction word.
REQ-014 SHALL have port out_valid  out  1  queue head holds a valid instruction.
REQ-015 SHALL have port out_instr  out  32  head instruction; 0 when out_valid=0.
REQ-016 SHALL have port out_pc  out  N  PC of head instruction; 0 when out_valid=0.
REQ-017 SHALL have port out_ready  in  1  decode consumes the head this cycle.
REQ-018 SHALL have port count  out  $clog2(DEPTH+1)  number of valid queue entries.

Function
REQ-019 SHALL implement a request FSM with states IDLE (nothing outstanding), WAIT (one accepted request outstanding), DROP (outstanding response to be discarded); at most one request outstanding.
REQ-020 SHALL drive imem_req=1 only in IDLE with count < DEPTH and reset=0; a request is accepted when imem_req=1 and imem_ready=1.
REQ-021 SHALL, on acceptance without redirect, latch the request PC, set PC <= PC+INC (modulo 2^N), and go to WAIT.
REQ-022 SHALL, in WAIT on imem_rvalid=1 without redirect, push {imem_rdata, latched PC} into the queue and go to IDLE; the response never arrives in the acceptance cycle.
REQ-023 SHALL, in DROP on imem_rvalid=1, discard the response and go to IDLE.
REQ-024 SHALL ignore imem_rvalid in IDLE.
REQ-025 SHALL, on PCSrc_F=1, set PC <= PCBranch_F, empty the queue (count=0, out_valid=0 next cycle), and override any increment.
REQ-026 SHALL, on redirect, go to DROP if in WAIT without rvalid, in DROP without rvalid, or in IDLE with a request accepted the same cycle; otherwise go to IDLE. A response arriving in the redirect cycle is discarded.
REQ-027 SHALL pop the head when out_valid=1 and out_ready=1; push and pop in the same cycle leave count unchanged.
REQ-028 SHALL not bypass: a pushed entry appears at the head no earlier than the next cycle.
REQ-029 SHALL wrap queue read and write pointers modulo DEPTH; the queue never overflows (REQ-020 reserves space).
REQ-030 SHALL present out_instr and out_pc from the head entry combinationally.

Reset
REQ-031 SHALL, while reset=1, hold imem_req=0; on the following edge set PC=RESET_PC, state=IDLE, count=0, pointers=0, out_valid=0.
REQ-032 SHALL abandon any outstanding request on reset; a response arriving after reset is ignored (IDLE).

Verification
REQ-033 Reset then imem_ready=1 and 1-cycle response latency, out_ready=0 -> addresses 0,4,8,12 issued, count reaches 4, imem_req stays 0 while full.
REQ-034 Full queue, out_ready=1 for one cycle -> count 3, one new request issued next cycle at address 16.
REQ-035 Request at 0x8 outstanding, PCSrc_F=1 with PCBranch_F=0x100 -> queue emptied, response to 0x8 discarded, next request address 0x100.
REQ-036 Redirect in the same cycle as imem_rvalid -> data not queued, FSM IDLE, next request at target.
REQ-037 Simultaneous push and pop with count=2 -> count stays 2, out_pc order preserved.
REQ-038 N=32, RESET_PC=0xFFFFFFFC -> first request 0xFFFFFFFC, second 0x00000000.
